// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer and its prefetch FIFO.
// The fetch FSM encodings are fixed so that debug views and traces stay stable.
package fetch_sequencer_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE       = 2'd0,
        FS_REQ        = 2'd1,
        FS_FLUSH_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the redirect, instruction-memory and decoder handshakes around the fetch sequencer.
// master = the sequencer itself, slave = memory/core side driving the opposite directions.
interface fetch_sequencer_if;
    import fetch_sequencer_pkg::*;

    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                imem_req;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_ack;
    logic [INSTR_W-1:0]  imem_rdata;
    logic [INSTR_W-1:0]  instruction;
    logic                instruction_RDY_BSY;
    logic [XLEN-1:0]     instr_pc;
    logic                decoder_rdy_bsy;

    modport master (
        input  redirect_valid, redirect_pc, imem_ack, imem_rdata, decoder_rdy_bsy,
        output imem_req, imem_addr, instruction, instruction_RDY_BSY, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ack, imem_rdata, decoder_rdy_bsy,
        input  imem_req, imem_addr, instruction, instruction_RDY_BSY, instr_pc
    );

endinterface

// File: rtl/fetch_sequencer_fifo.sv
// Prefetch FIFO of {pc, instruction} entries with synchronous clear.
// The head is read straight from storage and forced to zero while empty.
module fetch_sequencer_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  fetch_entry_t             push_data,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t     mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;

    // Pop is ignored while empty so the pointers can never run past the data.
    always_comb begin
        pop_ok_s = pop && (count_r != {CW{1'b0}});
        if (count_r != {CW{1'b0}}) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = '0;
        end
    end

    assign count = count_r;

    // Storage, pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequential req/ack fetches into a prefetch FIFO,
// ready/busy delivery to the decoder, and flush/refetch on redirect.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    fetch_sequencer_if.master   bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e     state_r, state_nxt_s;
    logic [XLEN-1:0]  fetch_pc_r, fetch_pc_nxt_s;
    logic [XLEN-1:0]  pend_addr_r, pend_addr_nxt_s;
    logic             pend_r, pend_nxt_s;
    logic [XLEN-1:0]  addr_s;
    logic             issue_s, req_s, ack_s, rdy_s;
    logic             push_s, pop_s, clr_s;
    logic [CW-1:0]    count_s;
    fetch_entry_t     head_s, push_entry_s;

    // A request already outstanding keeps its address; a new one is only raised
    // when the FIFO has room for it, so a push can never hit a full FIFO.
    always_comb begin
        issue_s      = (state_r == FS_REQ) && !pend_r && (count_s < DEPTH_C);
        req_s        = pend_r || issue_s;
        addr_s       = pend_r ? pend_addr_r : fetch_pc_r;
        ack_s        = req_s && bus.imem_ack;
        rdy_s        = (count_s != {CW{1'b0}});
        push_entry_s = '{pc: addr_s, instr: bus.imem_rdata};
    end

    // Next-state and FIFO control; redirect overrides every other action.
    always_comb begin
        state_nxt_s     = state_r;
        fetch_pc_nxt_s  = fetch_pc_r;
        pend_nxt_s      = pend_r;
        pend_addr_nxt_s = pend_addr_r;
        push_s          = 1'b0;
        clr_s           = 1'b0;
        pop_s           = rdy_s && bus.decoder_rdy_bsy && !bus.redirect_valid;
        case (state_r)
            FS_IDLE: begin
                state_nxt_s = FS_REQ;
                if (bus.redirect_valid) begin
                    clr_s          = 1'b1;
                    fetch_pc_nxt_s = word_align(bus.redirect_pc);
                end else begin
                    fetch_pc_nxt_s = fetch_pc_r;
                end
            end
            FS_REQ: begin
                if (bus.redirect_valid) begin
                    clr_s          = 1'b1;
                    fetch_pc_nxt_s = word_align(bus.redirect_pc);
                    if (req_s && !ack_s) begin
                        state_nxt_s     = FS_FLUSH_WAIT;
                        pend_nxt_s      = 1'b1;
                        pend_addr_nxt_s = addr_s;
                    end else begin
                        state_nxt_s = FS_REQ;
                        pend_nxt_s  = 1'b0;
                    end
                end else if (ack_s) begin
                    push_s         = 1'b1;
                    fetch_pc_nxt_s = addr_s + 32'd4;
                    pend_nxt_s     = 1'b0;
                end else if (req_s) begin
                    pend_nxt_s      = 1'b1;
                    pend_addr_nxt_s = addr_s;
                end else begin
                    pend_nxt_s = 1'b0;
                end
            end
            FS_FLUSH_WAIT: begin
                // The abandoned request is still on the bus; its data is dropped.
                if (bus.redirect_valid) begin
                    clr_s          = 1'b1;
                    fetch_pc_nxt_s = word_align(bus.redirect_pc);
                end else begin
                    fetch_pc_nxt_s = fetch_pc_r;
                end
                if (ack_s) begin
                    state_nxt_s = FS_REQ;
                    pend_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = FS_FLUSH_WAIT;
                end
            end
            default: begin
                state_nxt_s = FS_IDLE;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_r     <= FS_IDLE;
            fetch_pc_r  <= RESET_PC;
            pend_r      <= 1'b0;
            pend_addr_r <= RESET_PC;
        end else begin
            state_r     <= state_nxt_s;
            fetch_pc_r  <= fetch_pc_nxt_s;
            pend_r      <= pend_nxt_s;
            pend_addr_r <= pend_addr_nxt_s;
        end
    end

    fetch_sequencer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .clr       (clr_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_entry_s),
        .head      (head_s),
        .count     (count_s)
    );

    assign bus.imem_req            = req_s;
    assign bus.imem_addr           = addr_s;
    assign bus.instruction         = head_s.instr;
    assign bus.instr_pc            = head_s.pc;
    assign bus.instruction_RDY_BSY = rdy_s;

endmodule
